// File: rtl/comar_pkg.sv
// Shared definitions for the COMAR output demasking slice: FSM encoding and
// limits used when checking build parameters.
package comar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMBINE = 2'd2,
        OUT     = 2'd3
    } comar_state_e;

    localparam int COMAR_MAX_DELAY = 15;
    localparam int SHARES          = 2;

endpackage

// File: rtl/comar_demask_out_if.sv
// Handshake bundle of the demasking block: masked share pair in, unmasked
// word out. The slave modport is the block's own view.
interface comar_demask_out_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] share0;
    logic [WIDTH-1:0] share1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, share0, share1, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, share0, share1, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/comar_share_reg.sv
// WIDTH-bit holding register with async reset, synchronous clear and load.
// Clear wins over load so zeroization can never be skipped.
module comar_share_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/comar_demask_out.sv
// Output-end decoder: registers each share separately, waits DELAY cycles,
// recombines into u_q and offers the unmasked word on a valid/ready port.
module comar_demask_out
    import comar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    comar_demask_out_if.slave  bus
);

    generate
        if (WIDTH < 1 || WIDTH > 64 || DELAY < 1 || DELAY > COMAR_MAX_DELAY) begin : g_param_check
            $error("comar_demask_out: WIDTH must be 1..64 and DELAY 1..15");
        end
    endgenerate

    comar_state_e     r_state;
    logic [3:0]       r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_s0_q;
    logic [WIDTH-1:0] w_s1_q;
    logic [WIDTH-1:0] w_u_q;
    logic [WIDTH-1:0] w_u_d;
    logic             w_capture;
    logic             w_combine;
    logic             w_release;

    assign w_capture = (r_state == IDLE) && bus.in_valid;
    assign w_combine = (r_state == COMBINE);
    assign w_release = (r_state == OUT) && bus.out_ready;

    // Both shares are masked before the XOR so the recombination is silent
    // outside COMBINE; this is the only point where the shares meet.
    assign w_u_d = ({WIDTH{w_combine}} & w_s0_q) ^ ({WIDTH{w_combine}} & w_s1_q);

    comar_share_reg #(.WIDTH(WIDTH)) u_s0 (
        .clk(clk), .rst(rst), .i_clr(w_combine), .i_load(w_capture),
        .i_d(bus.share0), .o_q(w_s0_q)
    );

    comar_share_reg #(.WIDTH(WIDTH)) u_s1 (
        .clk(clk), .rst(rst), .i_clr(w_combine), .i_load(w_capture),
        .i_d(bus.share1), .o_q(w_s1_q)
    );

    comar_share_reg #(.WIDTH(WIDTH)) u_u (
        .clk(clk), .rst(rst), .i_clr(w_release), .i_load(w_combine),
        .i_d(w_u_d), .o_q(w_u_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt      <= 4'(DELAY - 1);
                        r_state    <= SETTLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= COMBINE;
                    end
                end
                COMBINE: begin
                    r_state     <= OUT;
                    r_out_valid <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? w_u_q : '0;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_comar_demask_out.sv
// Scoreboard bench for comar_demask_out: directed protocol cases on DELAY=1
// and DELAY=4 instances plus a long random run against an XOR reference.
module tb_comar_demask_out;
    import comar_pkg::*;

    logic clk;
    logic rst;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] expQ[$];
    logic [7:0] monExp;

    comar_demask_out_if #(.WIDTH(8)) bus1 ();
    comar_demask_out_if #(.WIDTH(8)) bus4 ();

    comar_demask_out #(.WIDTH(8), .DELAY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    comar_demask_out #(.WIDTH(8), .DELAY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkZeroized(input string tag);
        checkOutput({tag, "_s0"}, dut1.w_s0_q, 8'h00);
        checkOutput({tag, "_s1"}, dut1.w_s1_q, 8'h00);
        checkOutput({tag, "_u"},  dut1.w_u_q,  8'h00);
    endtask

    // Monitor: every output handshake must match the oldest expected word,
    // idle output must read 0 and an idle block must hold no secrets.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_word: got 0x%02h, expected no output at %0t",
                             bus1.out_data, $time);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("scoreboard_word", bus1.out_data, monExp);
                end
            end else if (!bus1.out_valid) begin
                checkOutput("data_zero_when_invalid", bus1.out_data, 8'h00);
            end
            if (!bus1.busy) begin
                checkZeroized("idle_zeroize");
            end
        end
    end

    // Offer a share pair to the DELAY=1 instance and hold it until taken;
    // returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus1.share0   = a;
        bus1.share1   = b;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus1.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            expQ.push_back(a ^ b);
            @(posedge clk);
            #1;
        end else begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
        end
        bus1.in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises; in_ready must stay low meanwhile.
    task automatic waitValid(input bit useD4, output int edges);
        logic ov;
        logic ir;
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            ov = useD4 ? bus4.out_valid : bus1.out_valid;
            ir = useD4 ? bus4.in_ready  : bus1.in_ready;
            if (ov) begin
                edges = i;
                break;
            end
            checkFlag("in_ready_low_while_busy", ir, 1'b0);
        end
    endtask

    logic [7:0] ra;
    logic [7:0] rb;
    int         edges;
    int         sent;
    int         cycles;
    bit         pending;
    bit         accepted;

    initial begin
        rst            = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.share0    = 8'h00;
        bus1.share1    = 8'h00;
        bus1.out_ready = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.share0    = 8'h00;
        bus4.share1    = 8'h00;
        bus4.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkFlag("reset_in_ready", bus1.in_ready, 1'b1);
        checkFlag("reset_out_valid", bus1.out_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkFlag("post_reset_in_ready", bus1.in_ready, 1'b1);
        checkFlag("post_reset_out_valid", bus1.out_valid, 1'b0);
        checkOutput("post_reset_out_data", bus1.out_data, 8'h00);
        checkFlag("post_reset_busy", bus1.busy, 1'b0);
        checkFlag("post_reset_busy_d4", bus4.busy, 1'b0);
        checkFlag("post_reset_in_ready_d4", bus4.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word, DELAY=1
        applyStimulus(8'hA5, 8'h3C);
        waitValid(1'b0, edges);
        checkCount("latency_delay1", edges, 2);
        checkOutput("single_word_data", bus1.out_data, 8'h99);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkFlag("single_ov_after_hs", bus1.out_valid, 1'b0);
        checkOutput("single_data_after_hs", bus1.out_data, 8'h00);
        checkFlag("single_in_ready_after_hs", bus1.in_ready, 1'b1);
        bus1.out_ready = 1'b0;

        // Settle delay, DELAY=4
        bus4.share0   = 8'hFF;
        bus4.share1   = 8'h0F;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        checkFlag("d4_ready_before_accept", bus4.in_ready, 1'b1);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        waitValid(1'b1, edges);
        checkCount("latency_delay4", edges, 5);
        checkOutput("d4_word_data", bus4.out_data, 8'hF0);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkFlag("d4_ov_after_hs", bus4.out_valid, 1'b0);
        checkFlag("d4_in_ready_after_hs", bus4.in_ready, 1'b1);
        bus4.out_ready = 1'b0;

        // Backpressure with a competing input offer
        applyStimulus(8'h5A, 8'h0F);
        waitValid(1'b0, edges);
        bus1.share0   = 8'h11;
        bus1.share1   = 8'h22;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkFlag("bp_out_valid_held", bus1.out_valid, 1'b1);
            checkOutput("bp_out_data_stable", bus1.out_data, 8'h55);
            checkFlag("bp_in_ready_low", bus1.in_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkFlag("no_accept_on_hs_edge", bus1.busy, 1'b0);
        checkFlag("bp_in_ready_after_hs", bus1.in_ready, 1'b1);
        @(negedge clk);
        expQ.push_back(8'h11 ^ 8'h22);
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        waitValid(1'b0, edges);
        checkOutput("bp_second_word", bus1.out_data, 8'h33);
        @(posedge clk);
        #1 bus1.out_ready = 1'b0;

        // Reset while in SETTLE (DELAY=4 instance also mid-settle)
        bus1.out_ready = 1'b1;
        bus4.share0    = 8'h12;
        bus4.share1    = 8'h34;
        bus4.in_valid  = 1'b1;
        applyStimulus(8'hDE, 8'hAD);
        bus4.in_valid  = 1'b0;
        #2 rst = 1'b1;
        expQ.delete();
        #1;
        checkFlag("rst_settle_in_ready", bus1.in_ready, 1'b1);
        checkFlag("rst_settle_busy", bus1.busy, 1'b0);
        checkFlag("rst_settle_busy_d4", bus4.busy, 1'b0);
        checkZeroized("rst_settle");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkFlag("rst_settle_no_output", bus1.out_valid, 1'b0);
            checkFlag("rst_settle_no_output_d4", bus4.out_valid, 1'b0);
        end

        // Reset while in OUT
        @(posedge clk);
        #1 bus1.out_ready = 1'b0;
        applyStimulus(8'h77, 8'h01);
        waitValid(1'b0, edges);
        checkOutput("rst_out_word_before", bus1.out_data, 8'h76);
        #2 rst = 1'b1;
        expQ.delete();
        #1;
        checkFlag("rst_out_out_valid", bus1.out_valid, 1'b0);
        checkOutput("rst_out_out_data", bus1.out_data, 8'h00);
        checkZeroized("rst_out");
        @(posedge clk);
        #1 rst = 1'b0;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkFlag("rst_out_no_output", bus1.out_valid, 1'b0);
        end

        // Random run: XOR reference, random producer gaps and consumer stalls
        sent     = 0;
        cycles   = 0;
        pending  = 1'b0;
        accepted = 1'b0;
        while ((sent < 1000 || expQ.size() != 0) && cycles < 30000) begin
            @(posedge clk);
            #1;
            if (accepted) begin
                bus1.in_valid = 1'b0;
                pending       = 1'b0;
                accepted      = 1'b0;
            end
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                ra            = 8'($urandom);
                rb            = 8'($urandom);
                bus1.share0   = ra;
                bus1.share1   = rb;
                bus1.in_valid = 1'b1;
                pending       = 1'b1;
            end
            bus1.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pending && bus1.in_ready) begin
                expQ.push_back(ra ^ rb);
                sent++;
                accepted = 1'b1;
            end
            cycles++;
        end
        checkCount("random_words_sent", sent, 1000);
        @(posedge clk);
        #1;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkCount("queue_drained", expQ.size(), 0);
        checkFlag("final_idle", bus1.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
